// File: rtl/gecko_writeback_ordered.sv
// gecko_writeback_ordered
// In-order writeback merger for the gecko pipeline. Several generic result
// channels plus one paired load channel (command + memory response) compete
// for a single registered writeback port. Each architectural register has an
// expected status tag; only the candidate whose tag matches may retire, so
// writes to one register leave in issue order whatever unit finishes first.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   res_valid/res_ready      generic channel handshake, one bit per channel
//   res_value/addr/status    packed per-channel result, destination, tag
//   res_speculative          per-channel speculative flag
//   mem_cmd_*                load command (dest reg, tag, funct3, byte offset)
//   mem_rsp_*                raw memory word, consumed together with the command
//   wb_valid/wb_ready        registered writeback handshake
//   wb_value/addr/status     retired value, register and tag
module gecko_writeback_ordered #(
  parameter int NUM_CHANNELS       = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int STATUS_WIDTH       = 2,
  parameter bit SQUASH_SPECULATIVE = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNELS-1:0]                res_valid,
  output logic [NUM_CHANNELS-1:0]                res_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     res_value,
  input  logic [NUM_CHANNELS*REG_ADDR_WIDTH-1:0] res_addr,
  input  logic [NUM_CHANNELS*STATUS_WIDTH-1:0]   res_status,
  input  logic [NUM_CHANNELS-1:0]                res_speculative,
  input  logic                                   mem_cmd_valid,
  output logic                                   mem_cmd_ready,
  input  logic [REG_ADDR_WIDTH-1:0]              mem_cmd_addr,
  input  logic [STATUS_WIDTH-1:0]                mem_cmd_status,
  input  logic [2:0]                             mem_cmd_op,
  input  logic [1:0]                             mem_cmd_offset,
  input  logic                                   mem_rsp_valid,
  output logic                                   mem_rsp_ready,
  input  logic [31:0]                            mem_rsp_data,
  output logic                                   wb_valid,
  input  logic                                   wb_ready,
  output logic [DATA_WIDTH-1:0]                  wb_value,
  output logic [REG_ADDR_WIDTH-1:0]              wb_addr,
  output logic [STATUS_WIDTH-1:0]                wb_status
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  logic [STATUS_WIDTH-1:0]   exp_q [NUM_REGS];
  logic [STATUS_WIDTH-1:0]   exp_d [NUM_REGS];
  logic                      wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0]     wb_value_q, wb_value_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [STATUS_WIDTH-1:0]   wb_status_q, wb_status_d;

  logic [31:0]               ld_shifted;
  logic [31:0]               ld_value;
  logic                      can_load;
  logic                      load_elig;
  logic                      gnt_load;
  logic [NUM_CHANNELS-1:0]   gnt_res;
  logic                      any_gnt;
  logic                      sel_spec;
  logic [DATA_WIDTH-1:0]     sel_value;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [STATUS_WIDTH-1:0]   sel_status;

  // Load alignment: the word is shifted down so the addressed byte sits at
  // bit 0. LW ignores the offset; unknown funct3 values behave as LW.
  always_comb begin
    ld_shifted = mem_rsp_data >> {mem_cmd_offset, 3'b000};
    case (mem_cmd_op)
      OP_LB:   ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      OP_LH:   ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      OP_LBU:  ld_value = {24'h0, ld_shifted[7:0]};
      OP_LHU:  ld_value = {16'h0, ld_shifted[15:0]};
      default: ld_value = mem_rsp_data;
    endcase
  end

  // Single-grant fixed-priority arbiter (load first, then channel 0 upward).
  // A lower-priority candidate that targets the same register as the winner
  // simply loses this cycle, which is how duplicate tags stall.
  always_comb begin
    can_load   = !wb_valid_q || wb_ready;
    load_elig  = mem_cmd_valid && mem_rsp_valid &&
                 (mem_cmd_status == exp_q[mem_cmd_addr]);
    gnt_load   = 1'b0;
    gnt_res    = '0;
    any_gnt    = 1'b0;
    sel_spec   = 1'b0;
    sel_value  = '0;
    sel_addr   = '0;
    sel_status = '0;
    if (can_load && !rst) begin
      if (load_elig) begin
        gnt_load   = 1'b1;
        any_gnt    = 1'b1;
        sel_value  = DATA_WIDTH'(ld_value);
        sel_addr   = mem_cmd_addr;
        sel_status = mem_cmd_status;
      end else begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (!any_gnt && res_valid[i] &&
              (res_status[i*STATUS_WIDTH +: STATUS_WIDTH] ==
               exp_q[res_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]])) begin
            gnt_res[i] = 1'b1;
            any_gnt    = 1'b1;
            sel_spec   = res_speculative[i];
            sel_value  = res_value[i*DATA_WIDTH +: DATA_WIDTH];
            sel_addr   = res_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            sel_status = res_status[i*STATUS_WIDTH +: STATUS_WIDTH];
          end
        end
      end
    end
  end

  // Tag advance and output stage. A squashed speculative grant still bumps
  // the tag but leaves the output register free.
  always_comb begin
    exp_d       = exp_q;
    wb_valid_d  = wb_valid_q && !wb_ready;
    wb_value_d  = wb_value_q;
    wb_addr_d   = wb_addr_q;
    wb_status_d = wb_status_q;
    if (any_gnt) begin
      exp_d[sel_addr] = exp_q[sel_addr] + STATUS_WIDTH'(1);
      if (!(sel_spec && SQUASH_SPECULATIVE)) begin
        wb_valid_d  = 1'b1;
        wb_value_d  = sel_value;
        wb_addr_d   = sel_addr;
        wb_status_d = sel_status;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) exp_q[r] <= '0;
      wb_valid_q  <= 1'b0;
      wb_value_q  <= '0;
      wb_addr_q   <= '0;
      wb_status_q <= '0;
    end else begin
      exp_q       <= exp_d;
      wb_valid_q  <= wb_valid_d;
      wb_value_q  <= wb_value_d;
      wb_addr_q   <= wb_addr_d;
      wb_status_q <= wb_status_d;
    end
  end

  assign res_ready     = gnt_res;
  assign mem_cmd_ready = gnt_load;
  assign mem_rsp_ready = gnt_load;
  assign wb_valid      = wb_valid_q;
  assign wb_value      = wb_value_q;
  assign wb_addr       = wb_addr_q;
  assign wb_status     = wb_status_q;

endmodule

// File: tb/tb_gecko_writeback_ordered.sv
// tb_gecko_writeback_ordered
// Directed bench for gecko_writeback_ordered (2 generic channels, 32-bit
// data, 32 registers, 2-bit tags). The stimulus process pushes each expected
// writeback beat into a scoreboard queue; a negedge monitor pops and compares
// whenever a beat is transferred. Ready/stability checks are made inline.
module tb_gecko_writeback_ordered;

  localparam int NCH = 2;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic [1:0]  status;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NCH-1:0]    res_valid;
  logic [NCH-1:0]    res_ready;
  logic [NCH*32-1:0] res_value;
  logic [NCH*5-1:0]  res_addr;
  logic [NCH*2-1:0]  res_status;
  logic [NCH-1:0]    res_speculative;
  logic          mem_cmd_valid, mem_cmd_ready;
  logic [4:0]    mem_cmd_addr;
  logic [1:0]    mem_cmd_status;
  logic [2:0]    mem_cmd_op;
  logic [1:0]    mem_cmd_offset;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [31:0]   mem_rsp_data;
  logic          wb_valid, wb_ready;
  logic [31:0]   wb_value;
  logic [4:0]    wb_addr;
  logic [1:0]    wb_status;

  int compared   = 0;
  int mismatched = 0;
  beat_t sb[$];

  gecko_writeback_ordered #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5),
    .STATUS_WIDTH(2), .SQUASH_SPECULATIVE(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_addr(res_addr), .res_status(res_status),
    .res_speculative(res_speculative),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_status(mem_cmd_status),
    .mem_cmd_op(mem_cmd_op), .mem_cmd_offset(mem_cmd_offset),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value),
    .wb_addr(wb_addr), .wb_status(wb_status)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a beat transfers on the next rising edge whenever
  // wb_valid and wb_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got value=%08h addr=%0d status=%0d, none expected",
                 wb_value, wb_addr, wb_status);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (wb_value !== e.value || wb_addr !== e.addr || wb_status !== e.status) begin
          mismatched++;
          $display("[TB] FAIL wb_beat: got value=%08h addr=%0d status=%0d, expected value=%08h addr=%0d status=%0d",
                   wb_value, wb_addr, wb_status, e.value, e.addr, e.status);
        end
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic expectBeat(input logic [31:0] v, input logic [4:0] a, input logic [1:0] s);
    beat_t b;
    b.value = v; b.addr = a; b.status = s;
    sb.push_back(b);
  endtask

  task automatic applyStimulus(input int ch, input logic v, input logic [4:0] a,
                               input logic [1:0] s, input logic [31:0] val, input logic spec);
    res_valid[ch]           = v;
    res_addr[ch*5 +: 5]     = a;
    res_status[ch*2 +: 2]   = s;
    res_value[ch*32 +: 32]  = val;
    res_speculative[ch]     = spec;
  endtask

  task automatic applyLoad(input logic cv, input logic rv, input logic [4:0] a, input logic [1:0] s,
                           input logic [2:0] op, input logic [1:0] off, input logic [31:0] data);
    mem_cmd_valid  = cv;
    mem_rsp_valid  = rv;
    mem_cmd_addr   = a;
    mem_cmd_status = s;
    mem_cmd_op     = op;
    mem_cmd_offset = off;
    mem_rsp_data   = data;
  endtask

  // One load pair that must handshake immediately and produce the given value.
  task automatic doLoad(input string name, input logic [4:0] a, input logic [2:0] op,
                        input logic [1:0] off, input logic [31:0] exp_val);
    applyLoad(1'b1, 1'b1, a, 2'd0, op, off, 32'hAABBCCDD);
    settle();
    checkOutput({name, "_ready"}, {30'd0, mem_cmd_ready, mem_rsp_ready}, 32'd3);
    expectBeat(exp_val, a, 2'd0);
    tick();
    applyLoad(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb_ready = 1'b1;
    res_valid = '0; res_value = '0; res_addr = '0; res_status = '0; res_speculative = '0;
    applyLoad(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    checkOutput("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("reset_wb_fields", {25'd0, wb_addr, wb_status} | wb_value, 32'd0);

    // Out-of-order arrival on register 0x1F.
    applyStimulus(0, 1'b1, 5'h1F, 2'd2, 32'h42, 1'b0);
    settle();
    checkOutput("ooo_ch0_wait0", {30'd0, res_ready}, 32'd0);
    tick();
    applyStimulus(1, 1'b1, 5'h1F, 2'd0, 32'h100, 1'b0);
    settle();
    checkOutput("ooo_tag0_ready", {30'd0, res_ready}, 32'b10);
    expectBeat(32'h100, 5'h1F, 2'd0);
    tick();
    checkOutput("ooo_tag0_latency", {31'd0, wb_valid}, 32'd1);
    applyStimulus(1, 1'b1, 5'h1F, 2'd1, 32'h101, 1'b0);
    settle();
    checkOutput("ooo_tag1_ready", {30'd0, res_ready}, 32'b10);
    expectBeat(32'h101, 5'h1F, 2'd1);
    tick();
    applyStimulus(1, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    settle();
    checkOutput("ooo_tag2_ready", {30'd0, res_ready}, 32'b01);
    expectBeat(32'h42, 5'h1F, 2'd2);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    tick();

    // Load alignment, each to a fresh register at tag 0.
    doLoad("lw_off2",  5'd10, 3'b010, 2'd2, 32'hAABBCCDD);
    doLoad("lb_off2",  5'd11, 3'b000, 2'd2, 32'hFFFFFFBB);
    doLoad("lbu_off3", 5'd12, 3'b100, 2'd3, 32'h000000AA);
    doLoad("lh_off2",  5'd13, 3'b001, 2'd2, 32'hFFFFAABB);
    doLoad("lhu_off0", 5'd14, 3'b101, 2'd0, 32'h0000CCDD);
    applyLoad(1'b1, 1'b0, 5'd15, 2'd0, 3'b010, 2'd0, 32'h12345678);
    settle();
    checkOutput("cmd_no_rsp", {30'd0, mem_cmd_ready, mem_rsp_ready}, 32'd0);
    tick();
    mem_rsp_valid = 1'b1;
    settle();
    checkOutput("cmd_late_rsp", {30'd0, mem_cmd_ready, mem_rsp_ready}, 32'd3);
    expectBeat(32'h12345678, 5'd15, 2'd0);
    tick();
    applyLoad(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0);
    tick();

    // Priority: load wins over channel 0 in the same cycle.
    applyLoad(1'b1, 1'b1, 5'd1, 2'd0, 3'b010, 2'd0, 32'h11111111);
    applyStimulus(0, 1'b1, 5'd2, 2'd0, 32'h22, 1'b0);
    settle();
    checkOutput("prio_load_first", {29'd0, mem_cmd_ready, res_ready}, 32'b100);
    expectBeat(32'h11111111, 5'd1, 2'd0);
    tick();
    applyLoad(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0);
    settle();
    checkOutput("prio_ch0_next", {30'd0, res_ready}, 32'b01);
    expectBeat(32'h22, 5'd2, 2'd0);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    tick();

    // Backpressure with three eligible results pending.
    wb_ready = 1'b0;
    applyLoad(1'b1, 1'b1, 5'd8, 2'd0, 3'b010, 2'd0, 32'hC0);
    applyStimulus(0, 1'b1, 5'd4, 2'd0, 32'hA0, 1'b0);
    applyStimulus(1, 1'b1, 5'd6, 2'd0, 32'hB0, 1'b0);
    settle();
    checkOutput("bp_first_grant", {29'd0, mem_cmd_ready, res_ready}, 32'b100);
    expectBeat(32'hC0, 5'd8, 2'd0);
    tick();
    applyLoad(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0);
    for (int c = 0; c < 5; c++) begin
      settle();
      checkOutput("bp_no_ready", {30'd0, res_ready}, 32'd0);
      checkOutput("bp_hold_value", wb_value, 32'hC0);
      checkOutput("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
      tick();
    end
    wb_ready = 1'b1;
    settle();
    checkOutput("bp_release_ch0", {30'd0, res_ready}, 32'b01);
    expectBeat(32'hA0, 5'd4, 2'd0);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    settle();
    checkOutput("bp_release_ch1", {30'd0, res_ready}, 32'b10);
    expectBeat(32'hB0, 5'd6, 2'd0);
    tick();
    applyStimulus(1, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    tick();

    // Speculative squash on register 5 through a full tag wrap.
    for (int t = 0; t < 4; t++) begin
      applyStimulus(0, 1'b1, 5'd5, 2'(t), 32'h50 + 32'(t), 1'b1);
      settle();
      checkOutput("spec_ready", {30'd0, res_ready}, 32'b01);
      tick();
      checkOutput("spec_no_beat", {31'd0, wb_valid}, 32'd0);
    end
    applyStimulus(0, 1'b1, 5'd5, 2'd0, 32'h55, 1'b0);
    settle();
    checkOutput("wrap_tag0_ready", {30'd0, res_ready}, 32'b01);
    expectBeat(32'h55, 5'd5, 2'd0);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    tick();

    // Reset mid-operation with expected[7] = 2 and a beat stuck in output.
    applyStimulus(1, 1'b1, 5'd7, 2'd0, 32'h70, 1'b0);
    expectBeat(32'h70, 5'd7, 2'd0);
    tick();
    applyStimulus(1, 1'b1, 5'd7, 2'd1, 32'h71, 1'b0);
    tick();
    wb_ready = 1'b0;
    rst = 1'b1;
    applyStimulus(1, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
    applyStimulus(0, 1'b1, 5'd9, 2'd0, 32'h99, 1'b0);
    settle();
    checkOutput("rst_pre_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("rst_no_ready", {30'd0, res_ready}, 32'd0);
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    applyStimulus(0, 1'b1, 5'd7, 2'd0, 32'h77, 1'b0);
    settle();
    checkOutput("rst_wb_cleared", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_tag_cleared", {30'd0, res_ready}, 32'b01);
    expectBeat(32'h77, 5'd7, 2'd0);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);

    // Bounded drain of the scoreboard.
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    tick();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gecko_writeback_ordered.md
Name: gecko_writeback_ordered

Overview:
- N-channel in-order writeback merger for the gecko pipeline.
- Inputs: NUM_CHANNELS generic result streams (execute, system, future units) plus one load channel that pairs each memory command with its memory response.
- Ordering: tracks an expected status tag per architectural register and only retires the result whose reg_status matches. Per-register writes therefore leave in issue order regardless of which unit finishes first.
- Output: a single registered writeback stream feeding the register file and forwarding logic.

Parameters:
- NUM_CHANNELS, 2, number of generic result channels (1..8)
- DATA_WIDTH, 32, result value width (32 only for the load path; generic channels accept any width)
- REG_ADDR_WIDTH, 5, register address width; counter table holds 2**REG_ADDR_WIDTH entries
- STATUS_WIDTH, 2, reg_status tag width; tags wrap modulo 2**STATUS_WIDTH
- SQUASH_SPECULATIVE, 1, when 1, speculative results retire silently (no output beat)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- res_valid  in  NUM_CHANNELS  generic channel valid
- res_ready  out  NUM_CHANNELS  generic channel ready
- res_value  in  NUM_CHANNELS*DATA_WIDTH  result value, channel i at slice i
- res_addr  in  NUM_CHANNELS*REG_ADDR_WIDTH  destination register
- res_status  in  NUM_CHANNELS*STATUS_WIDTH  reg_status tag
- res_speculative  in  NUM_CHANNELS  speculative flag
- mem_cmd_valid / mem_cmd_ready  in/out  1  load command handshake
- mem_cmd_addr  in  REG_ADDR_WIDTH  load destination register
- mem_cmd_status  in  STATUS_WIDTH  load tag
- mem_cmd_op  in  3  RV32I load funct3
- mem_cmd_offset  in  2  byte offset within word
- mem_rsp_valid / mem_rsp_ready  in/out  1  memory data handshake
- mem_rsp_data  in  32  raw loaded word
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback ready
- wb_value  out  DATA_WIDTH  retired value
- wb_addr  out  REG_ADDR_WIDTH  retired register
- wb_status  out  STATUS_WIDTH  retired tag

Behaviour:
- Reset (synchronous, 1 cycle):
  - all expected-tag entries cleared to 0
  - wb_valid=0; wb_value/addr/status=0
  - all ready outputs 0 while rst=1
  - any in-flight beat is discarded; the load pair is not consumed.
- Load candidate exists only when mem_cmd_valid and mem_rsp_valid are both 1. Its command and response are consumed in the same cycle; mem_cmd_ready == mem_rsp_ready.
- Eligibility: a candidate is eligible when its tag == expected[addr].
- Arbitration:
  - at most one grant per cycle, only when the output stage can load (!wb_valid || wb_ready)
  - fixed priority: load channel, then generic channel 0, 1, ...
  - ready is asserted only to the granted channel, in the same cycle (combinational from valid/tag/table).
- On grant: expected[addr] <= expected[addr]+1 (mod 2**STATUS_WIDTH), visible next cycle.
- Output:
  - if the granted result is speculative and SQUASH_SPECULATIVE=1, the tag still advances and no output beat is produced
  - otherwise the output register loads on the next edge: latency 1 cycle from handshake to wb_valid
  - wb_* hold stable while wb_valid && !wb_ready; no grant occurs in that state.
- Load alignment: shifted = mem_rsp_data >> (8*offset).
  - LB 000: sign-extend byte
  - LH 001: sign-extend halfword
  - LW 010: full word, offset ignored
  - LBU 100: zero-extend byte
  - LHU 101: zero-extend halfword
  - other funct3: treated as LW
- Same register, two eligible candidates (duplicate tag, protocol error): the lower-priority one stalls.
- Tags for different registers are independent. Non-eligible candidates wait indefinitely without blocking others.
- Tag wrap: expected value 3 advances to 0 (STATUS_WIDTH=2).

Test Plan:
- Out-of-order arrival. Ch0 presents {addr 0x1F, status 2, value 0x42}; next cycle ch1 presents {0x1F, status 0}, then {0x1F, status 1}. Required: wb beats leave in tag order 0, 1, 2, each valid one cycle after its handshake; ch0 stays not-ready until tag 2 is expected.
- Load alignment. LW offset 2 with data 0xAABBCCDD yields 0xAABBCCDD. LB offset 2 yields 0xFFFFFFBB. LBU offset 3 yields 0x000000AA. LH offset 2 yields 0xFFFFAABB. LHU offset 0 yields 0x0000CCDD. Command without a response: no handshake.
- Priority. Load {addr 1, tag 0} and ch0 {addr 2, tag 0} both eligible in the same cycle. Required: load granted first, ch0 granted next cycle.
- Backpressure. Hold wb_ready=0 for 5 cycles with 3 pending eligible results. Required: wb_* stable, no ready asserted, all 3 retire in order once wb_ready=1.
- Speculative squash and wrap. Four speculative results to addr 5, tags 0..3. Required: no wb beats and expected[5] back to 0; a subsequent tag-0 non-speculative result then retires.
- Reset mid-operation. Assert rst while wb_valid=1 and expected[7]=2. Required: wb_valid=0 the next cycle, and a fresh tag-0 result to addr 7 is accepted.
